// File: rtl/alu_cmd_sequencer.sv
// Command front-end for the 8-bit ALU: buffers commands in a FIFO, issues them one at a time,
// holds ALU inputs across the registered result cycle and returns tagged responses in order.
module alu_cmd_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [7:0]       cmd_a,
    input  logic [7:0]       cmd_b,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [3:0]       alu_op,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    input  logic [7:0]       alu_result,
    input  logic [15:0]      alu_product,
    input  logic             alu_of,
    input  logic             alu_zero,
    input  logic             alu_slt,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_result,
    output logic [15:0]      rsp_product,
    output logic [2:0]       rsp_flags,
    output logic             rsp_illegal,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             busy
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPT, RESP} state_t;

    state_t state;
    state_t next_state;

    logic [3:0]       fifo_op  [FIFO_DEPTH];
    logic [7:0]       fifo_a   [FIFO_DEPTH];
    logic [7:0]       fifo_b   [FIFO_DEPTH];
    logic [TAG_W-1:0] fifo_tag [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             fifo_empty;
    logic             push;
    logic             pop;

    logic [3:0]       iss_op;
    logic [7:0]       iss_a;
    logic [7:0]       iss_b;
    logic [TAG_W-1:0] iss_tag;

    assign fifo_empty = (count == '0);
    assign cmd_ready  = (count < CNT_W'(FIFO_DEPTH));
    assign push       = cmd_valid && cmd_ready;
    assign pop        = !fifo_empty &&
                        ((state == IDLE) || ((state == RESP) && rsp_ready));

    // Storage needs no reset; only count and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_op[wr_ptr]  <= cmd_op;
            fifo_a[wr_ptr]   <= cmd_a;
            fifo_b[wr_ptr]   <= cmd_b;
            fifo_tag[wr_ptr] <= cmd_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            iss_op  <= 4'b1111;
            iss_a   <= '0;
            iss_b   <= '0;
            iss_tag <= '0;
        end else if (pop) begin
            iss_op  <= fifo_op[rd_ptr];
            iss_a   <= fifo_a[rd_ptr];
            iss_b   <= fifo_b[rd_ptr];
            iss_tag <= fifo_tag[rd_ptr];
        end
    end

    // Response registers only load in CAPT, so they stay frozen while RESP is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_result  <= '0;
            rsp_product <= '0;
            rsp_flags   <= '0;
            rsp_illegal <= 1'b0;
            rsp_tag     <= '0;
        end else if (state == CAPT) begin
            rsp_result  <= alu_result;
            rsp_product <= alu_product;
            rsp_flags   <= {alu_slt, alu_zero, alu_of};
            rsp_illegal <= iss_op[3] & iss_op[2];
            rsp_tag     <= iss_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    next_state = ISSUE;
                end
            end
            ISSUE: next_state = CAPT;
            CAPT:  next_state = RESP;
            RESP: begin
                if (rsp_ready) begin
                    next_state = fifo_empty ? IDLE : ISSUE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // ALU inputs stay valid through CAPT because the overflow flag is combinational.
    always_comb begin
        alu_op    = 4'b1111;
        alu_a     = '0;
        alu_b     = '0;
        rsp_valid = 1'b0;
        if ((state == ISSUE) || (state == CAPT)) begin
            alu_op = iss_op;
            alu_a  = iss_a;
            alu_b  = iss_b;
        end
        if (state == RESP) begin
            rsp_valid = 1'b1;
        end
    end

    assign busy = (state != IDLE) || !fifo_empty;

endmodule
